// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - serial program loader filling instruction memory from a framed byte stream
//
// Purpose: accepts SYNC, LEN_HI, LEN_LO, LEN x {HI, LO}, CHK over a valid/ready
// byte link, writes each 16-bit word to instruction memory and holds the CPU
// off until a frame with a good XOR checksum has been loaded.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   byte_data/valid   incoming byte stream
//   byte_ready        loader can take a byte (low only in the write cycle)
//   mem_en_write      one-cycle write strobe per word
//   mem_addr/mem_data write address and data, stable while the strobe is high
//   cpu_hold          keeps the CPU stalled during and after a failed load
//   done/error        status of the last frame
module prog_loader #(
  parameter int          ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_en_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
    S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  // Largest legal word count; kept wide so the compare is valid for any ADDR_W.
  localparam logic [32:0] MAX_LEN = 33'd1 << ADDR_W;

  state_t            state_q, state_d;
  logic [7:0]        xor_q, xor_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              xfer;
  logic              is_sync;
  logic [15:0]       len;

  assign byte_ready = (state_q != S_WRITE);
  assign xfer       = byte_valid && byte_ready;
  assign is_sync    = (byte_data == SYNC_BYTE);
  assign len        = {len_hi_q, byte_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      xor_q    <= 8'd0;
      len_hi_q <= 8'd0;
      hi_q     <= 8'd0;
      words_q  <= 16'd0;
      addr_q   <= '0;
      data_q   <= 16'd0;
      hold_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      xor_q    <= xor_d;
      len_hi_q <= len_hi_d;
      hi_q     <= hi_d;
      words_q  <= words_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    xor_d    = xor_q;
    len_hi_d = len_hi_q;
    hi_d     = hi_q;
    words_d  = words_q;
    addr_d   = addr_q;
    data_d   = data_q;
    hold_d   = hold_q;
    done_d   = done_q;
    error_d  = error_q;

    case (state_q)
      // SYNC is only recognised between frames; inside a frame A5 is data.
      S_IDLE, S_DONE, S_ERR: begin
        if (xfer && is_sync) begin
          state_d = S_LEN_HI;
          xor_d   = 8'd0;
          addr_d  = '0;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_hi_d = byte_data;
          xor_d    = xor_q ^ byte_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          xor_d   = xor_q ^ byte_data;
          words_d = len;
          if ({17'd0, len} > MAX_LEN) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else if (len == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (xfer) begin
          hi_d    = byte_data;
          xor_d   = xor_q ^ byte_data;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (xfer) begin
          data_d  = {hi_q, byte_data};
          xor_d   = xor_q ^ byte_data;
          state_d = S_WRITE;
        end
      end
      // Strobe cycle: address advances as the memory captures the word.
      S_WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        words_d = words_q - 16'd1;
        state_d = (words_q == 16'd1) ? S_CHK : S_DATA_HI;
      end
      S_CHK: begin
        if (xfer) begin
          if (byte_data == xor_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_en_write = (state_q == S_WRITE);
  assign mem_addr     = addr_q;
  assign mem_data     = data_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader
module tb_prog_loader;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_en_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              cpu_hold;
  logic              done;
  logic              error;

  prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .mem_en_write (mem_en_write),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  int cyc      = 0;
  logic prev_en = 1'b0;

  logic [31:0] exp_q[$];   // {addr, data} of each expected write
  logic [15:0] fw[$];      // words of the frame being sent

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      if (mem_en_write) begin
        n_writes++;
        check("en_single_cycle", {31'd0, prev_en}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {22'd0, mem_addr}, {16'd0, e[31:16]});
          check("wr_data", {16'd0, mem_data}, {16'd0, e[15:0]});
        end
      end
      if (!byte_ready) check("ready_low_only_in_write", {31'd0, mem_en_write}, 32'd1);
    end
    prev_en = mem_en_write;
  end

  // Called at a negedge; returns at the negedge following the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int t = 0;
    int gap;
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready && t < 8) begin
      @(negedge clk);
      t++;
    end
    if (t >= 8) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic send_frame(input bit bad_chk, input int max_gap);
    logic [7:0]  x;
    logic [15:0] n;
    n = 16'(fw.size());
    x = n[15:8] ^ n[7:0];
    send_byte(8'hA5, max_gap);
    send_byte(n[15:8], max_gap);
    send_byte(n[7:0], max_gap);
    for (int i = 0; i < fw.size(); i++) begin
      x = x ^ fw[i][15:8] ^ fw[i][7:0];
      send_byte(fw[i][15:8], max_gap);
      exp_q.push_back({16'(i), fw[i]});
      send_byte(fw[i][7:0], max_gap);
    end
    send_byte(bad_chk ? (x ^ 8'hFF) : x, max_gap);
    byte_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, byte_ready}, 32'd1);
    check({tag, "_en"},    {31'd0, mem_en_write}, 32'd0);
    check({tag, "_addr"},  {22'd0, mem_addr}, 32'd0);
    check({tag, "_data"},  {16'd0, mem_data}, 32'd0);
    check({tag, "_hold"},  {31'd0, cpu_hold}, 32'd0);
    check({tag, "_done"},  {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    int c0;
    int w0;
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Good 3-word frame, valid held high: 10 bytes + 3 write stalls.
    fw = '{16'h1234, 16'hABCD, 16'h0001};
    c0 = cyc;
    send_frame(1'b0, 0);
    check("b2b_cycles", 32'(cyc - c0), 32'd13);
    check("good_done",  {31'd0, done}, 32'd1);
    check("good_error", {31'd0, error}, 32'd0);
    check("good_hold",  {31'd0, cpu_hold}, 32'd0);
    check("good_addr",  {22'd0, mem_addr}, 32'd3);
    check("good_data",  {16'd0, mem_data}, 32'h0001);

    // Bad checksum, then a good frame clears error.
    send_frame(1'b1, 0);
    check("badchk_error", {31'd0, error}, 32'd1);
    check("badchk_done",  {31'd0, done}, 32'd0);
    check("badchk_hold",  {31'd0, cpu_hold}, 32'd1);
    send_byte(8'h3C, 0);  // stray byte in ERR is dropped
    fw = '{16'hBEEF, 16'h0F0F};
    send_frame(1'b0, 1);
    check("recover_done",  {31'd0, done}, 32'd1);
    check("recover_error", {31'd0, error}, 32'd0);
    check("recover_addr",  {22'd0, mem_addr}, 32'd2);

    // Oversize length 0x0401 > 1024.
    w0 = n_writes;
    send_byte(8'hA5, 0);
    check("sync_hold_rise", {31'd0, cpu_hold}, 32'd1);
    check("sync_clears_done", {31'd0, done}, 32'd0);
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    byte_valid = 1'b0;
    check("oversize_error", {31'd0, error}, 32'd1);
    check("oversize_hold",  {31'd0, cpu_hold}, 32'd1);
    repeat (3) @(negedge clk);
    check("oversize_nowrite", 32'(n_writes - w0), 32'd0);

    // Zero-length frame: XOR covers only the length bytes.
    fw = {};
    send_frame(1'b0, 0);
    check("len0_done", {31'd0, done}, 32'd1);
    check("len0_addr", {22'd0, mem_addr}, 32'd0);

    // Exactly 2^ADDR_W words is legal; address wraps to 0.
    fw = {};
    for (int i = 0; i < (1 << ADDR_W); i++) fw.push_back(16'(i * 37 + 5));
    w0 = n_writes;
    send_frame(1'b0, 0);
    check("full_done",   {31'd0, done}, 32'd1);
    check("full_writes", 32'(n_writes - w0), 32'(1 << ADDR_W));
    check("full_addr",   {22'd0, mem_addr}, 32'd0);

    // Random gaps, reset mid-frame after the second HI byte.
    send_byte(8'hA5, 2);
    send_byte(8'h00, 2);
    send_byte(8'h03, 2);
    send_byte(8'h12, 2);
    exp_q.push_back({16'd0, 16'h1234});
    send_byte(8'h34, 2);
    send_byte(8'hAB, 2);
    byte_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_hold", {31'd0, cpu_hold}, 32'd1);
    w0 = n_writes;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_nowrite", 32'(n_writes - w0), 32'd0);
    check("midrst_queue",   32'(exp_q.size()), 32'd0);
    fw = '{16'hCAFE, 16'h1111};
    send_frame(1'b0, 3);
    check("after_rst_done", {31'd0, done}, 32'd1);
    check("after_rst_addr", {22'd0, mem_addr}, 32'd2);

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
